// File: rtl/vgafb_fifo_downsize_pkg.sv
// vgafb_fifo_downsize_pkg
//   Shared definitions for the vgafb width-converting FIFOs.
//   - VGAFB_MSB_FIRST / VGAFB_LSB_FIRST : sub-word order encodings for lsb_first
//   - vgafb_clog2                       : ceiling log2, usable in parameter expressions
//   - vgafb_level_width                 : width of an occupancy counter that must hold
//                                         0..DEPTH*R inclusive (hence the extra bit)
package vgafb_fifo_downsize_pkg;

  localparam logic VGAFB_MSB_FIRST = 1'b0;
  localparam logic VGAFB_LSB_FIRST = 1'b1;

  function automatic int vgafb_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int vgafb_level_width(input int depth_log2, input int ratio);
    return depth_log2 + vgafb_clog2(ratio) + 1;
  endfunction

endpackage

// File: rtl/vgafb_fifo_slice_sel.sv
// vgafb_fifo_slice_sel
//   Combinational IW -> OW slice multiplexer shared by the vgafb width converters.
//   Ports:
//     word      in  IW        full-width word to split
//     idx       in  log2(R)   sub-word index, 0 = first slice delivered
//     lsb_first in  1         0: slice 0 is the most-significant OW bits, 1: least-significant
//     slice     out OW        selected sub-word
module vgafb_fifo_slice_sel
  import vgafb_fifo_downsize_pkg::*;
#(
  parameter int IW = 32,
  parameter int OW = 16
) (
  input  logic [IW-1:0]                    word,
  input  logic [vgafb_clog2(IW/OW)-1:0]    idx,
  input  logic                             lsb_first,
  output logic [OW-1:0]                    slice
);

  localparam int RL = vgafb_clog2(IW / OW);

  // Physical slice position counted from the LSB. With R a power of two,
  // R-1-idx is simply the bitwise complement of idx.
  logic [RL-1:0] pos;

  assign pos   = (lsb_first == VGAFB_LSB_FIRST) ? idx : ~idx;
  assign slice = word[int'(pos) * OW +: OW];

endmodule

// File: rtl/vgafb_fifo_downsize.sv
// vgafb_fifo_downsize
//   Width-reducing FIFO between the vgafb DMA master and the pixel pipeline.
//   IW-bit words are stored whole and handed out as R = IW/OW narrower words,
//   one per pop, in a selectable sub-word order.
//   Ports:
//     sys_clk    in   1    clock, rising edge
//     vga_rst    in   1    asynchronous active-high reset
//     flush      in   1    synchronous clear of pointers, level and flags
//     lsb_first  in   1    sub-word order (keep static while level != 0)
//     stb        in   1    write di this cycle
//     di         in   IW   input word
//     can_burst  out  1    room for a full BURST_WORDS burst
//     do_valid   out  1    do_data holds valid data
//     do_data    out  OW   current output word ("do" is a reserved word in SystemVerilog)
//     next       in   1    pop the current output word
//     level      out  LW   occupancy in OW words, 0..DEPTH*R
//     overflow   out  1    sticky: write attempted while full
//     underflow  out  1    sticky: pop attempted while empty
module vgafb_fifo_downsize
  import vgafb_fifo_downsize_pkg::*;
#(
  parameter int IW          = 32,
  parameter int OW          = 16,
  parameter int DEPTH_LOG2  = 4,
  parameter int BURST_WORDS = 4
) (
  input  logic                                              sys_clk,
  input  logic                                              vga_rst,
  input  logic                                              flush,
  input  logic                                              lsb_first,
  input  logic                                              stb,
  input  logic [IW-1:0]                                     di,
  output logic                                              can_burst,
  output logic                                              do_valid,
  output logic [OW-1:0]                                     do_data,
  input  logic                                              next,
  output logic [vgafb_level_width(DEPTH_LOG2, IW/OW)-1:0]   level,
  output logic                                              overflow,
  output logic                                              underflow
);

  localparam int R     = IW / OW;
  localparam int RL    = vgafb_clog2(R);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = vgafb_level_width(DEPTH_LOG2, R);
  localparam int CW    = DEPTH_LOG2 + RL;

  localparam logic [LW-1:0] FULL_LIMIT  = LW'(DEPTH * R - R);
  localparam logic [LW-1:0] BURST_LIMIT = LW'(DEPTH * R - BURST_WORDS * R);
  localparam logic [LW-1:0] RATIO       = LW'(R);

  if ((IW % OW) != 0 || R < 2 || (R & (R - 1)) != 0 ||
      BURST_WORDS < 1 || BURST_WORDS > DEPTH) begin : g_bad_params
    $error("vgafb_fifo_downsize: IW/OW must be a power of two >= 2 and 1 <= BURST_WORDS <= DEPTH");
  end

  logic [IW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] produce;
  logic [CW-1:0]         consume;
  logic                  full;
  logic                  empty;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [LW-1:0]         level_nxt;
  logic [OW-1:0]         slice;

  // Full means less than one whole free entry; the check uses the registered
  // level, so a same-cycle pop never makes room for a write.
  assign full  = level > FULL_LIMIT;
  assign empty = level == '0;

  // flush dominates both strobes for the cycle it is high.
  assign wr_ok = stb  && !full  && !flush;
  assign rd_ok = next && !empty && !flush;

  always_comb begin
    level_nxt = level;
    if (wr_ok) level_nxt = level_nxt + RATIO;
    if (rd_ok) level_nxt = level_nxt - 1'b1;
  end

  // Storage carries no reset; it is only meaningful behind the level count.
  always_ff @(posedge sys_clk) begin
    if (wr_ok && !vga_rst) mem[produce] <= di;
  end

  // Pointers wrap naturally at their widths; level disambiguates full/empty.
  always_ff @(posedge sys_clk or posedge vga_rst) begin
    if (vga_rst) begin
      produce   <= '0;
      consume   <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      produce   <= '0;
      consume   <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) produce <= produce + 1'b1;
      if (rd_ok) consume <= consume + 1'b1;
      level <= level_nxt;
      if (stb && full)   overflow  <= 1'b1;
      if (next && empty) underflow <= 1'b1;
    end
  end

  // Upper consume bits pick the entry, low bits pick the slice within it.
  vgafb_fifo_slice_sel #(
    .IW (IW),
    .OW (OW)
  ) u_slice_sel (
    .word      (mem[consume[CW-1:RL]]),
    .idx       (consume[RL-1:0]),
    .lsb_first (lsb_first),
    .slice     (slice)
  );

  assign do_valid  = !empty;
  assign do_data   = do_valid ? slice : '0;
  assign can_burst = level <= BURST_LIMIT;

endmodule
